// File: rtl/pcim_rd_arbiter.sv
// pcim_rd_arbiter: shares the single PCIM AXI4 read master among NREQ DMA
// readers. Round-robin arbitration on AR, requester index carried in ARID,
// R beats steered back by RID[2:0], per-requester outstanding-burst limit.
// Optional statistics counters are built when PCIM_RD_ARB_STATS_EN is defined.
module pcim_rd_arbiter #(
    parameter int NREQ      = 4,
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 512,
    parameter int ID_W      = 16,
    parameter int MAX_OUTST = 8
) (
    input  logic                     clk_main_a0,
    input  logic                     rst_main,
    input  logic [NREQ-1:0]          req_arvalid,
    input  logic [NREQ*ADDR_W-1:0]   req_araddr,
    input  logic [NREQ*8-1:0]        req_arlen,
    output logic [NREQ-1:0]          req_arready,
    output logic                     pcim_arvalid,
    output logic [ADDR_W-1:0]        pcim_araddr,
    output logic [7:0]               pcim_arlen,
    output logic [2:0]               pcim_arsize,
    output logic [ID_W-1:0]          pcim_arid,
    input  logic                     pcim_arready,
    input  logic                     pcim_rvalid,
    input  logic [ID_W-1:0]          pcim_rid,
    input  logic [DATA_W-1:0]        pcim_rdata,
    input  logic [1:0]               pcim_rresp,
    input  logic                     pcim_rlast,
    output logic                     pcim_rready,
    output logic [NREQ-1:0]          rsp_rvalid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [1:0]               rsp_rresp,
    output logic                     rsp_rlast,
    input  logic [NREQ-1:0]          rsp_rready,
`ifdef PCIM_RD_ARB_STATS_EN
    output logic [NREQ*32-1:0]       stat_grants,
    output logic [31:0]              stat_stall,
`endif
    output logic                     err_bad_rid
);

    localparam int IDX_W = 3;
    localparam int CNT_W = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]         state;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   rr_ptr;
    logic [ADDR_W-1:0]  araddr_q;
    logic [7:0]         arlen_q;
    logic [NREQ-1:0]    req_arready_q;
    logic [CNT_W-1:0]   outst [NREQ];

    logic [NREQ-1:0]    eligible;
    logic [2*NREQ-1:0]  elig_dbl;
    logic [NREQ-1:0]    elig_rot;
    logic               pick_valid;
    logic [IDX_W-1:0]   pick_idx;
    logic               ar_hs;
    logic [IDX_W-1:0]   r_idx;
    logic               r_in_range;
    logic               r_done;

    assign ar_hs      = (state == ST_HOLD) && pcim_arready;
    assign r_idx      = pcim_rid[IDX_W-1:0];
    assign r_in_range = int'(r_idx) < NREQ;
    assign r_done     = pcim_rvalid && pcim_rready && pcim_rlast && r_in_range;

    // A requester competes only while it is below its outstanding-burst limit.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            eligible[i] = req_arvalid[i] && (outst[i] < CNT_W'(MAX_OUTST));
        end
    end

    // Rotate so bit 0 is the rr pointer position; first set bit wins.
    assign elig_dbl = {eligible, eligible} >> rr_ptr;
    assign elig_rot = elig_dbl[NREQ-1:0];

    // Round-robin pick: first eligible requester at or after rr_ptr.
    always_comb begin
        // NOTE: defaults before the loop keep this purely combinational (no latch).
        int sum;
        pick_valid = 1'b0;
        pick_idx   = '0;
        sum        = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (elig_rot[k]) begin
                sum = int'(rr_ptr) + k;
                if (sum >= NREQ) sum = sum - NREQ;
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(sum);
            end
        end
    end

    // AR FSM: capture the winner in IDLE, hold the fields until the shell accepts.
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            state         <= ST_IDLE;
            grant_idx     <= '0;
            rr_ptr        <= '0;
            araddr_q      <= '0;
            arlen_q       <= '0;
            req_arready_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            req_arready_q <= '0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_idx     <= pick_idx;
                        araddr_q      <= req_araddr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        arlen_q       <= req_arlen[int'(pick_idx)*8 +: 8];
                        req_arready_q <= NREQ'(1) << pick_idx;
                        state         <= ST_HOLD;
                    end
                end
                default: begin
                    if (pcim_arready) begin
                        rr_ptr <= (int'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
                        state  <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Outstanding-burst counters: +1 on AR handshake, -1 on last R beat.
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            // NOTE: this small counter array is reset explicitly; it is state, not a RAM.
            for (int i = 0; i < NREQ; i++) outst[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (ar_hs && grant_idx == IDX_W'(i) && !(r_done && r_idx == IDX_W'(i))) begin
                    outst[i] <= outst[i] + 1'b1;
                end else if (r_done && r_idx == IDX_W'(i) && !(ar_hs && grant_idx == IDX_W'(i))
                             && outst[i] != '0) begin
                    outst[i] <= outst[i] - 1'b1;
                end
            end
        end
    end

    // Sticky flag for beats whose RID does not map to any requester.
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            err_bad_rid <= 1'b0;
        end else if (pcim_rvalid && !r_in_range) begin
            err_bad_rid <= 1'b1;
        end
    end

    // R steering: unknown RIDs are accepted and dropped so the shell never stalls.
    always_comb begin
        rsp_rvalid  = '0;
        pcim_rready = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (int'(r_idx) == i) begin
                rsp_rvalid[i] = pcim_rvalid;
                pcim_rready   = rsp_rready[i];
            end
        end
    end

    assign rsp_rdata    = pcim_rdata;
    assign rsp_rresp    = pcim_rresp;
    assign rsp_rlast    = pcim_rlast;
    assign req_arready  = req_arready_q;
    assign pcim_arvalid = (state == ST_HOLD);
    assign pcim_araddr  = araddr_q;
    assign pcim_arlen   = arlen_q;
    assign pcim_arsize  = 3'b110;
    assign pcim_arid    = ID_W'(grant_idx);

`ifdef PCIM_RD_ARB_STATS_EN
    logic [31:0] grants_q [NREQ];
    logic [31:0] stall_q;

    // Grant counters wrap; stall counter saturates.
    always_ff @(posedge clk_main_a0 or posedge rst_main) begin
        if (rst_main) begin
            for (int i = 0; i < NREQ; i++) grants_q[i] <= '0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (ar_hs && grant_idx == IDX_W'(i)) grants_q[i] <= grants_q[i] + 1'b1;
            end
            if (state == ST_HOLD && !pcim_arready && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NREQ; i++) stat_grants[i*32 +: 32] = grants_q[i];
    end
    assign stat_stall = stall_q;
`endif

endmodule

// File: tb/tb_pcim_rd_arbiter.sv
// Directed self-checking bench for pcim_rd_arbiter (NREQ=4, MAX_OUTST=8).
// Define PCIM_RD_ARB_STATS_EN to also exercise the statistics counters.
module tb_pcim_rd_arbiter;

    localparam int NREQ      = 4;
    localparam int ADDR_W    = 64;
    localparam int DATA_W    = 512;
    localparam int ID_W      = 16;
    localparam int MAX_OUTST = 8;

    logic                   clk_main_a0;
    logic                   rst_main;
    logic [NREQ-1:0]        req_arvalid;
    logic [NREQ*ADDR_W-1:0] req_araddr;
    logic [NREQ*8-1:0]      req_arlen;
    logic [NREQ-1:0]        req_arready;
    logic                   pcim_arvalid;
    logic [ADDR_W-1:0]      pcim_araddr;
    logic [7:0]             pcim_arlen;
    logic [2:0]             pcim_arsize;
    logic [ID_W-1:0]        pcim_arid;
    logic                   pcim_arready;
    logic                   pcim_rvalid;
    logic [ID_W-1:0]        pcim_rid;
    logic [DATA_W-1:0]      pcim_rdata;
    logic [1:0]             pcim_rresp;
    logic                   pcim_rlast;
    logic                   pcim_rready;
    logic [NREQ-1:0]        rsp_rvalid;
    logic [DATA_W-1:0]      rsp_rdata;
    logic [1:0]             rsp_rresp;
    logic                   rsp_rlast;
    logic [NREQ-1:0]        rsp_rready;
`ifdef PCIM_RD_ARB_STATS_EN
    logic [NREQ*32-1:0]     stat_grants;
    logic [31:0]            stat_stall;
`endif
    logic                   err_bad_rid;

    int n_assert = 0;
    int n_fail   = 0;

    pcim_rd_arbiter #(
        .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk_main_a0 (clk_main_a0),
        .rst_main    (rst_main),
        .req_arvalid (req_arvalid),
        .req_araddr  (req_araddr),
        .req_arlen   (req_arlen),
        .req_arready (req_arready),
        .pcim_arvalid(pcim_arvalid),
        .pcim_araddr (pcim_araddr),
        .pcim_arlen  (pcim_arlen),
        .pcim_arsize (pcim_arsize),
        .pcim_arid   (pcim_arid),
        .pcim_arready(pcim_arready),
        .pcim_rvalid (pcim_rvalid),
        .pcim_rid    (pcim_rid),
        .pcim_rdata  (pcim_rdata),
        .pcim_rresp  (pcim_rresp),
        .pcim_rlast  (pcim_rlast),
        .pcim_rready (pcim_rready),
        .rsp_rvalid  (rsp_rvalid),
        .rsp_rdata   (rsp_rdata),
        .rsp_rresp   (rsp_rresp),
        .rsp_rlast   (rsp_rlast),
        .rsp_rready  (rsp_rready),
`ifdef PCIM_RD_ARB_STATS_EN
        .stat_grants (stat_grants),
        .stat_stall  (stat_stall),
`endif
        .err_bad_rid (err_bad_rid)
    );

    initial clk_main_a0 = 1'b0;
    always #5 clk_main_a0 = ~clk_main_a0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_main_a0);
        #1;
    endtask

    task automatic idle_inputs();
        req_arvalid  = '0;
        pcim_arready = 1'b0;
        pcim_rvalid  = 1'b0;
        pcim_rid     = '0;
        pcim_rdata   = '0;
        pcim_rresp   = 2'b00;
        pcim_rlast   = 1'b0;
        rsp_rready   = '1;
    endtask

    task automatic do_reset();
        rst_main = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst_main = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [63:0] addr, input logic [7:0] len);
        req_araddr[i*ADDR_W +: ADDR_W] = addr;
        req_arlen[i*8 +: 8]            = len;
    endtask

    initial begin
        logic [63:0] exp_rdata;
        int          seq3 [4];
        seq3 = '{2, 3, 0, 2};

        req_araddr = '0;
        req_arlen  = '0;
        do_reset();

        // Reset values
        check("rst_arvalid", 64'(pcim_arvalid), 64'd0);
        check("rst_arready", 64'(req_arready), 64'd0);
        check("rst_araddr", pcim_araddr, 64'd0);
        check("rst_arlen", 64'(pcim_arlen), 64'd0);
        check("rst_arid", 64'(pcim_arid), 64'd0);
        check("rst_arsize", 64'(pcim_arsize), 64'd6);
        check("rst_err", 64'(err_bad_rid), 64'd0);
`ifdef PCIM_RD_ARB_STATS_EN
        check("rst_stat_grants", stat_grants[63:0], 64'd0);
        check("rst_stat_stall", 64'(stat_stall), 64'd0);
`endif

        // 1: single request from req0, then four R beats
        pcim_arready = 1'b1;
        set_req(0, 64'h1000, 8'd3);
        req_arvalid = 4'b0001;
        #1;
        check("t1_arvalid_pre", 64'(pcim_arvalid), 64'd0);
        tick();
        check("t1_arvalid", 64'(pcim_arvalid), 64'd1);
        check("t1_araddr", pcim_araddr, 64'h1000);
        check("t1_arlen", 64'(pcim_arlen), 64'd3);
        check("t1_arid", 64'(pcim_arid), 64'd0);
        check("t1_req_arready", 64'(req_arready), 64'b0001);
        req_arvalid = '0;
        tick();
        check("t1_arvalid_done", 64'(pcim_arvalid), 64'd0);
        check("t1_req_arready_done", 64'(req_arready), 64'd0);
        pcim_rvalid = 1'b1;
        pcim_rid    = 16'd0;
        rsp_rready  = 4'b1110;
        #1;
        check("t1_rready_bp", 64'(pcim_rready), 64'd0);
        rsp_rready = '1;
        for (int b = 0; b < 4; b++) begin
            exp_rdata               = 64'hDA7A_0000_0000_0000 + 64'(b);
            pcim_rdata              = '0;
            pcim_rdata[63:0]        = exp_rdata;
            pcim_rdata[511:448]     = ~exp_rdata;
            pcim_rresp              = 2'(b);
            pcim_rlast              = (b == 3);
            #1;
            check("t1_rsp_rvalid", 64'(rsp_rvalid), 64'b0001);
            check("t1_rsp_rdata_lo", rsp_rdata[63:0], exp_rdata);
            check("t1_rsp_rdata_hi", rsp_rdata[511:448], ~exp_rdata);
            check("t1_rsp_rresp", 64'(rsp_rresp), 64'(b));
            check("t1_rsp_rlast", 64'(rsp_rlast), 64'(b == 3));
            check("t1_pcim_rready", 64'(pcim_rready), 64'd1);
            tick();
        end
        pcim_rvalid = 1'b0;
        pcim_rlast  = 1'b0;

        // 2: all four requesting continuously, grants 0,1,2,3,0,1,2,3 two cycles apart
        do_reset();
        pcim_arready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_req(i, 64'h2000 + 64'(i) * 64'h100, 8'(i));
        req_arvalid = 4'b1111;
        for (int g = 0; g < 8; g++) begin
            tick();
            check("t2_arvalid_hi", 64'(pcim_arvalid), 64'd1);
            check("t2_arid", 64'(pcim_arid), 64'(g % 4));
            check("t2_req_arready", 64'(req_arready), 64'(1) << (g % 4));
            check("t2_araddr", pcim_araddr, 64'h2000 + 64'(g % 4) * 64'h100);
            check("t2_arlen", 64'(pcim_arlen), 64'(g % 4));
            tick();
            check("t2_arvalid_lo", 64'(pcim_arvalid), 64'd0);
        end
`ifdef PCIM_RD_ARB_STATS_EN
        check("t2_stat_grants0", 64'(stat_grants[31:0]), 64'd2);
        check("t2_stat_grants3", 64'(stat_grants[127:96]), 64'd2);
`endif
        req_arvalid = '0;

        // 3: req1 fills its 8 outstanding slots, is skipped, re-enters after one rlast
        do_reset();
        pcim_arready = 1'b1;
        set_req(1, 64'h3000, 8'd0);
        req_arvalid = 4'b0010;
        for (int g = 0; g < MAX_OUTST; g++) begin
            tick();
            check("t3_fill_arready", 64'(req_arready), 64'b0010);
            tick();
        end
        req_arvalid = 4'b1111;
        for (int g = 0; g < 4; g++) begin
            tick();
            check("t3_skip_arready", 64'(req_arready), 64'(1) << seq3[g]);
            check("t3_skip_arid", 64'(pcim_arid), 64'(seq3[g]));
            tick();
        end
        req_arvalid = 4'b0010;
        tick();
        check("t3_masked_arvalid", 64'(pcim_arvalid), 64'd0);
        check("t3_masked_arready", 64'(req_arready), 64'd0);
        pcim_rvalid = 1'b1;
        pcim_rid    = 16'd1;
        pcim_rlast  = 1'b1;
        #1;
        check("t3_rsp_rvalid", 64'(rsp_rvalid), 64'b0010);
        tick();
        check("t3_still_idle", 64'(pcim_arvalid), 64'd0);
        pcim_rvalid = 1'b0;
        pcim_rlast  = 1'b0;
        tick();
        check("t3_reenter_arready", 64'(req_arready), 64'b0010);
        check("t3_reenter_arid", 64'(pcim_arid), 64'd1);
        req_arvalid = '0;
        tick();

        // 4: pcim_arready held low, AR fields stay put, no new grant pulse
        do_reset();
        set_req(2, 64'hABCD_0000, 8'd7);
        req_arvalid = 4'b0100;
        tick();
        check("t4_first_arready", 64'(req_arready), 64'b0100);
        set_req(2, 64'h5555_0000, 8'd1);
        req_arvalid = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t4_hold_arvalid", 64'(pcim_arvalid), 64'd1);
            check("t4_hold_araddr", pcim_araddr, 64'hABCD_0000);
            check("t4_hold_arlen", 64'(pcim_arlen), 64'd7);
            check("t4_hold_arid", 64'(pcim_arid), 64'd2);
            check("t4_hold_arready", 64'(req_arready), 64'd0);
        end
`ifdef PCIM_RD_ARB_STATS_EN
        check("t4_stat_stall", 64'(stat_stall), 64'd5);
`endif
        pcim_arready = 1'b1;
        tick();
        check("t4_release_arvalid", 64'(pcim_arvalid), 64'd0);
        tick();
        check("t4_next_arid", 64'(pcim_arid), 64'd3);
        req_arvalid = '0;
        tick();

        // 5: RID outside the requester range is dropped and flagged
        do_reset();
        rsp_rready  = '0;
        pcim_rvalid = 1'b1;
        pcim_rid    = 16'd5;
        pcim_rlast  = 1'b1;
        #1;
        check("t5_rready", 64'(pcim_rready), 64'd1);
        check("t5_rsp_rvalid", 64'(rsp_rvalid), 64'd0);
        check("t5_err_pre", 64'(err_bad_rid), 64'd0);
        tick();
        check("t5_err_set", 64'(err_bad_rid), 64'd1);
        pcim_rid = 16'd3;
        #1;
        check("t5_rid3_rvalid", 64'(rsp_rvalid), 64'b1000);
        check("t5_rid3_rready", 64'(pcim_rready), 64'd0);
        pcim_rvalid = 1'b0;
        tick();
        check("t5_err_sticky", 64'(err_bad_rid), 64'd1);
        do_reset();
        check("t5_err_cleared", 64'(err_bad_rid), 64'd0);

        // 6: async reset while in HOLD clears AR state immediately
        pcim_arready = 1'b1;
        set_req(0, 64'h6000, 8'd2);
        set_req(1, 64'h6100, 8'd4);
        req_arvalid = 4'b0001;
        tick();
        req_arvalid = '0;
        tick();
        pcim_arready = 1'b0;
        req_arvalid  = 4'b0010;
        tick();
        check("t6_hold_arvalid", 64'(pcim_arvalid), 64'd1);
        check("t6_hold_arid", 64'(pcim_arid), 64'd1);
        #2;
        rst_main = 1'b1;
        #1;
        check("t6_async_arvalid", 64'(pcim_arvalid), 64'd0);
        check("t6_async_araddr", pcim_araddr, 64'd0);
        check("t6_async_arid", 64'(pcim_arid), 64'd0);
`ifdef PCIM_RD_ARB_STATS_EN
        check("t6_stat_grants", stat_grants[63:0], 64'd0);
`endif
        @(posedge clk_main_a0);
        #1;
        rst_main     = 1'b0;
        pcim_arready = 1'b1;
        req_arvalid  = 4'b1111;
        tick();
        check("t6_rr_reset_arid", 64'(pcim_arid), 64'd0);
        check("t6_rr_reset_arready", 64'(req_arready), 64'b0001);
        req_arvalid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
